drum_dot_acc: RTL and testbench

//   Signed accumulator directly downstream of the DRUM approximate multiplier.

---
 rtl/drum_pkg.sv | 17 +
 rtl/drum_sat_add.sv | 34 +++
 rtl/drum_dot_acc.sv | 92 +++++++++
 tb/tb_drum_dot_acc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and constants for the DRUM multiply-accumulate datapath.
package drum_pkg;

  typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  localparam int DEF_MAX_TERMS = 16;
  localparam int CNT_W         = $clog2(DEF_MAX_TERMS + 1);

  function automatic longint sat_max(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int aw);
    return -(64'sd1 <<< (aw - 1));
  endfunction

endpackage

// File: rtl/drum_sat_add.sv
// Combinational sign-extending saturating adder: acc + prod clamped to AW bits.
module drum_sat_add
  import drum_pkg::*;
#(
  parameter int PW = 16,
  parameter int AW = 24
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  localparam logic signed [AW:0] MAX_V = (AW+1)'(sat_max(AW));
  localparam logic signed [AW:0] MIN_V = (AW+1)'(sat_min(AW));

  function automatic logic signed [AW-1:0] sat_clamp(input logic signed [AW:0] v);
    if (v > MAX_V)      return MAX_V[AW-1:0];
    else if (v < MIN_V) return MIN_V[AW-1:0];
    else                return v[AW-1:0];
  endfunction

  logic signed [AW:0] acc_x;
  logic signed [AW:0] prod_x;
  logic signed [AW:0] wide;

  // One guard bit is enough: two AW-bit signed operands cannot overflow AW+1.
  assign acc_x  = $signed({acc[AW-1], acc});
  assign prod_x = $signed({{(AW + 1 - PW){prod[PW-1]}}, prod});
  assign wide   = acc_x + prod_x;
  assign sum    = sat_clamp(wide);
  assign ovf    = (wide > MAX_V) | (wide < MIN_V);

endmodule

// File: rtl/drum_dot_acc.sv
// Frame accumulator behind the DRUM multiplier: sums signed products per frame
// and holds the saturated result on an output handshake.
module drum_dot_acc
  import drum_pkg::*;
#(
  parameter int PW        = 16,
  parameter int AW        = 24,
  parameter int MAX_TERMS = DEF_MAX_TERMS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PW-1:0]                  in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [AW-1:0]                  out_sum,
  output logic [$clog2(MAX_TERMS+1)-1:0] out_count,
  output logic                           out_sat
);

  localparam int CW = $clog2(MAX_TERMS + 1);

  state_t               state, state_nx;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] add_sum;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 sat_flag, ovf, xfer, close;

  assign in_ready = (state == S_ACC) & ~clear & rst_n;
  assign xfer     = in_valid & in_ready;
  assign cnt_nx   = cnt + 1'b1;
  assign close    = xfer & (in_last | (cnt_nx == CW'(MAX_TERMS)));

  drum_sat_add #(.PW(PW), .AW(AW)) u_add (
    .acc (acc),
    .prod(in_prod),
    .sum (add_sum),
    .ovf (ovf)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_ACC:   if (close) state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = S_ACC;
      default: state_nx = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nx;
  end

  // The closing beat's post-update values go straight into the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (state == S_ACC) begin
      if (clear) begin
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else if (xfer) begin
        acc      <= add_sum;
        cnt      <= cnt_nx;
        sat_flag <= sat_flag | ovf;
        if (close) begin
          out_sum   <= add_sum;
          out_count <= cnt_nx;
          out_sat   <= sat_flag | ovf;
          out_valid <= 1'b1;
        end
      end
    end else if (out_ready) begin
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_drum_dot_acc.sv
// Scoreboard bench for drum_dot_acc: one 24-bit and one 17-bit instance share stimulus.
module tb_drum_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [23:0] sum_a;
  logic [4:0]  count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [16:0] sum_b;
  logic [4:0]  count_b;

  always #5 clk = ~clk;

  drum_dot_acc #(.PW(16), .AW(24), .MAX_TERMS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_count(count_a), .out_sat(out_sat_a)
  );

  drum_dot_acc #(.PW(16), .AW(17), .MAX_TERMS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_count(count_b), .out_sat(out_sat_b)
  );

  typedef struct {
    longint a;
    longint b;
    bit     sa;
    bit     sb;
    int     c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: running per-frame sums with clamping after every term.
  longint fa, fb;
  bit     fsa, fsb;
  int     fc;
  bit     holding;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clampw(input longint v, input int aw, inout bit hit);
    longint mx, mn;
    mx = (64'sd1 <<< (aw - 1)) - 1;
    mn = -(64'sd1 <<< (aw - 1));
    if (v > mx) begin hit = 1'b1; return mx; end
    if (v < mn) begin hit = 1'b1; return mn; end
    return v;
  endfunction

  task automatic model_reset();
    fa = 0; fb = 0; fsa = 0; fsb = 0; fc = 0;
  endtask

  task automatic model_accept(input longint p, input bit last);
    exp_t e;
    fa = clampw(fa + p, 24, fsa);
    fb = clampw(fb + p, 17, fsb);
    fc++;
    if (last || fc == 16) begin
      e.a = fa; e.b = fb; e.sa = fsa; e.sb = fsb; e.c = fc;
      q.push_back(e);
      model_reset();
      holding = 1'b1;
    end
  endtask

  // One clock of stimulus; readiness and result visibility are predicted by the model.
  task automatic cyc(input bit v, input logic [15:0] p, input bit last, input bit clr, input bit ordy);
    @(negedge clk);
    in_valid = v; in_prod = p; in_last = last; clear = clr; out_ready = ordy;
    #1;
    chk("in_ready_a", longint'(in_ready_a), longint'(!holding && !clr));
    chk("in_ready_b", longint'(in_ready_b), longint'(!holding && !clr));
    chk("out_valid", longint'(out_valid_a), longint'(holding));
    if (holding) begin
      if (ordy) holding = 1'b0;
    end else if (clr) begin
      model_reset();
    end else if (v) begin
      model_accept(longint'($signed(p)), last);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; clear = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("in_ready_in_reset", longint'(in_ready_a | in_ready_b), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();
    holding = 1'b0;
    #1;
    chk("rst_in_ready", longint'(in_ready_a & in_ready_b), 1);
    chk("rst_out_valid", longint'(out_valid_a | out_valid_b), 0);
    chk("rst_out_sum", longint'(sum_a) + longint'(sum_b), 0);
    chk("rst_out_count", longint'(count_a) + longint'(count_b), 0);
    chk("rst_out_sat", longint'(out_sat_a | out_sat_b), 0);
  endtask

  // Monitor: pops an expectation when a result appears, then checks it stays put.
  initial begin
    bit   prev_v = 1'b0;
    exp_t cur;
    cur = '{a: 0, b: 0, sa: 0, sb: 0, c: 0};
    forever begin
      @(posedge clk);
      #1;
      if (out_valid_a === 1'b1 && !prev_v) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got sum %0d, expected no result", $signed(sum_a));
        end else begin
          cur = q.pop_front();
          chk("sum_a", longint'($signed(sum_a)), cur.a);
          chk("sum_b", longint'($signed(sum_b)), cur.b);
          chk("sat_a", longint'(out_sat_a), longint'(cur.sa));
          chk("sat_b", longint'(out_sat_b), longint'(cur.sb));
          chk("count_a", longint'(count_a), longint'(cur.c));
          chk("count_b", longint'(count_b), longint'(cur.c));
          chk("out_valid_b", longint'(out_valid_b), 1);
        end
      end else if (out_valid_a === 1'b1) begin
        chk("held_sum_a", longint'($signed(sum_a)), cur.a);
        chk("held_sum_b", longint'($signed(sum_b)), cur.b);
        chk("held_count", longint'(count_a), longint'(cur.c));
      end
      prev_v = (out_valid_a === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] p;
    model_reset();
    holding = 1'b0;

    do_reset(2);

    cyc(1, 16'd100, 0, 0, 1);
    cyc(1, -16'sd30, 0, 0, 1);
    cyc(1, 16'd5, 1, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    for (int i = 0; i < 16; i++) cyc(1, 16'h7FFF, 0, 0, 1);
    cyc(1, 16'h7FFF, 0, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    for (int i = 0; i < 4; i++) cyc(1, 16'h7FFF, i == 3, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 16'h8000, i == 3, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    // Closing beat that is also the 16th term: one result only.
    for (int i = 0; i < 16; i++) cyc(1, 16'd1, i == 15, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    cyc(1, 16'd50, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'd123, 0, i == 2, 0);
    cyc(1, 16'd123, 0, 0, 1);
    cyc(1, 16'd7, 1, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    cyc(1, 16'd10, 0, 0, 1);
    cyc(1, 16'd20, 0, 0, 1);
    cyc(1, 16'd99, 0, 1, 1);
    cyc(1, 16'd3, 1, 0, 0);
    cyc(0, 16'd0, 0, 0, 0);
    do_reset(1);

    cyc(1, 16'd40, 0, 0, 1);
    cyc(1, 16'd41, 0, 0, 1);
    do_reset(1);
    cyc(1, 16'd2, 1, 0, 1);
    cyc(0, 16'd0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 16'h7FFF;
        1:       p = 16'h8000;
        default: p = 16'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else cyc($urandom_range(0, 9) < 7, p, $urandom_range(0, 4) == 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    for (int i = 0; i < 4; i++) cyc(0, 16'd0, 0, 0, 1);
    chk("results_drained", longint'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
